fetch_controller: RTL and testbench
===================================

// Module: fetch_controller
// PURPOSE
//   Fetch-stage initiator that drives the instruction memory's address, read, write, CS and
//   writeData inputs, and captures its 16-bit readData. It holds the PC and loads a 32-bit
//   reset vector from memory. It fetches one- and two-word instructions, redirects on
//   branches and stalls on request. Its output registers feed the fetch/decode pipeline register.
// PARAMETERS
//   RESET_VEC   32'h0000_0000  word address of reset vector (low half at RESET_VEC, high at +1)
//   IMM_PREFIX  2'b11          instr[15:14] value marking a two-word (immediate) instruction
// PORTS
//   clk            in   1   clock, all state updates on posedge
//   rst_n          in   1   asynchronous, active-low reset
//   mem_address    out  32  word address to instruction memory (combinational from state/PC)
//   mem_read       out  1   memory read strobe
//   mem_write      out  1   memory write strobe, tied 0
//   mem_CS         out  1   memory chip select
//   mem_writeData  out  16  tied 16'h0000
//   mem_readData   in   16  instruction word, valid combinationally in the same cycle as mem_address
//   stall          in   1   hold all fetch state (hazard from later stages)
//   branch_taken   in   1   redirect fetch to branch_target
//   branch_target  in   32  redirect word address
//   instr          out  16  fetched instruction word
//   imm            out  16  second word of two-word instruction (held from last one otherwise)
//   pc_out         out  32  address of the first word of instr
//   valid          out  1   instr/imm/pc_out form a complete instruction
// BEHAVIOUR
//   States: VEC_LO -> VEC_HI -> FETCH <-> FETCH_IMM. Encoding is free.
//   Reset (rst_n=0, asynchronous): state=VEC_LO, pc=0, instr=0, imm=0, pc_out=0, valid=0.
//     Reset mid-operation abandons any partial fetch immediately.
//   Memory interface: mem_read=1 and mem_CS=1 in every state while rst_n=1; both are 0 while
//     rst_n=0. mem_write=0 and mem_writeData=0 at all times.
//     mem_address = RESET_VEC in VEC_LO, RESET_VEC+1 in VEC_HI, pc in FETCH and FETCH_IMM.
//   VEC_LO: pc[15:0] <= mem_readData; go to VEC_HI.
//   VEC_HI: pc[31:16] <= mem_readData; go to FETCH.
//     stall and branch_taken are ignored in both vector states, which take exactly 2 cycles.
//   Priority in FETCH and FETCH_IMM: branch_taken > stall > normal.
//     branch_taken: pc <= branch_target, valid <= 0, state <= FETCH. A pending immediate
//       fetch is discarded. instr, imm and pc_out hold.
//     stall (no branch): pc, state, instr, imm, pc_out and valid all hold.
//       mem_address is therefore stable, and reads repeat harmlessly.
//   FETCH, normal: instr <= mem_readData, pc_out <= pc, pc <= pc+1.
//     If mem_readData[15:14] == IMM_PREFIX: valid <= 0, go to FETCH_IMM.
//     Otherwise: valid <= 1, stay in FETCH.
//   FETCH_IMM, normal: imm <= mem_readData, pc <= pc+1, valid <= 1, go to FETCH.
//   Latency: a one-word instruction is presented 1 cycle after its address is driven. A
//     two-word instruction is presented 2 cycles after its first address. Throughput is 1 word per cycle.
//   Arithmetic: pc+1 is modulo 2^32, so 32'hFFFF_FFFF wraps to 0. The memory decodes
//     address[19:0]; this block does no range check.
//   Consumer contract: the downstream register samples instr, imm, pc_out and valid on the same
//     edge as this block. While valid=1 and stall=1, the outputs stay constant.
// TESTING
//   1 mem[0]=16'h0020, mem[1]=0, mem[32]=16'h1940; release rst_n -> mem_address 0, 1, then 32;
//     next cycle valid=1, instr=16'h1940, pc_out=32'h20; mem_address=32'h21.
//   2 mem[32]=16'hC123, mem[33]=16'h00FF -> valid=0 for one cycle; then valid=1,
//     instr=16'hC123, imm=16'h00FF, pc_out=32'h20; mem_address=32'h22.
//   3 stall=1 for 3 cycles mid-stream -> mem_address, instr, pc_out and valid are unchanged
//     for all 3 cycles; the stream resumes without loss or duplication.
//   4 In FETCH_IMM with stall=1, branch_taken=1, target 32'h40 -> next cycle mem_address=32'h40,
//     valid=0, state FETCH; mem[0x40] is fetched the following cycle.
//   5 Branch to 32'hFFFF_FFFF holding a one-word instruction -> valid=1, pc_out=32'hFFFF_FFFF,
//     mem_address=0. Then assert rst_n=0 mid-fetch -> all outputs 0 and mem_read=0 asynchronously;
//     mem_address=RESET_VEC.

Source files
------------

// File: rtl/fetch_controller.sv
// Fetch-stage initiator: boots the PC from a two-word reset vector, then streams
// one- and two-word instructions from instruction memory with branch redirect and stall.
module fetch_controller #(
    parameter logic [31:0] RESET_VEC  = 32'h0000_0000,
    parameter logic [1:0]  IMM_PREFIX = 2'b11
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] mem_address,
    output logic        mem_read,
    output logic        mem_write,
    output logic        mem_CS,
    output logic [15:0] mem_writeData,
    input  logic [15:0] mem_readData,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    output logic [15:0] instr,
    output logic [15:0] imm,
    output logic [31:0] pc_out,
    output logic        valid
);

    typedef enum logic [1:0] {VEC_LO, VEC_HI, FETCH, FETCH_IMM} state_t;

    state_t      state, state_nxt;
    logic [31:0] pc, pc_nxt;
    logic [15:0] instr_nxt, imm_nxt;
    logic [31:0] pc_out_nxt;
    logic        valid_nxt;

    // Strobes follow reset directly so they drop asynchronously with rst_n.
    assign mem_read      = rst_n;
    assign mem_CS        = rst_n;
    assign mem_write     = 1'b0;
    assign mem_writeData = 16'h0000;

    always_comb begin
        mem_address = pc;
        case (state)
            VEC_LO:  mem_address = RESET_VEC;
            VEC_HI:  mem_address = RESET_VEC + 32'd1;
            default: mem_address = pc;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= VEC_LO;
            pc     <= 32'h0;
            instr  <= 16'h0;
            imm    <= 16'h0;
            pc_out <= 32'h0;
            valid  <= 1'b0;
        end else begin
            state  <= state_nxt;
            pc     <= pc_nxt;
            instr  <= instr_nxt;
            imm    <= imm_nxt;
            pc_out <= pc_out_nxt;
            valid  <= valid_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        pc_nxt     = pc;
        instr_nxt  = instr;
        imm_nxt    = imm;
        pc_out_nxt = pc_out;
        valid_nxt  = valid;
        case (state)
            VEC_LO: begin
                pc_nxt    = {pc[31:16], mem_readData};
                state_nxt = VEC_HI;
            end
            VEC_HI: begin
                pc_nxt    = {mem_readData, pc[15:0]};
                state_nxt = FETCH;
            end
            FETCH: begin
                if (branch_taken) begin
                    pc_nxt    = branch_target;
                    valid_nxt = 1'b0;
                    state_nxt = FETCH;
                end else if (!stall) begin
                    instr_nxt  = mem_readData;
                    pc_out_nxt = pc;
                    pc_nxt     = pc + 32'd1;
                    if (mem_readData[15:14] == IMM_PREFIX) begin
                        valid_nxt = 1'b0;
                        state_nxt = FETCH_IMM;
                    end else begin
                        valid_nxt = 1'b1;
                    end
                end
            end
            FETCH_IMM: begin
                // A redirect here drops the half-fetched two-word instruction.
                if (branch_taken) begin
                    pc_nxt    = branch_target;
                    valid_nxt = 1'b0;
                    state_nxt = FETCH;
                end else if (!stall) begin
                    imm_nxt   = mem_readData;
                    pc_nxt    = pc + 32'd1;
                    valid_nxt = 1'b1;
                    state_nxt = FETCH;
                end
            end
            default: state_nxt = VEC_LO;
        endcase
    end

endmodule

// File: tb/tb_fetch_controller.sv
// Self-checking bench for fetch_controller: directed boot/immediate/stall/branch/reset
// scenarios plus a randomized stream checked against an instruction-level memory decode.
module tb_fetch_controller;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] mem_address;
    logic        mem_read, mem_write, mem_CS;
    logic [15:0] mem_writeData, mem_readData;
    logic        stall = 1'b0;
    logic        branch_taken = 1'b0;
    logic [31:0] branch_target = 32'h0;
    logic [15:0] instr, imm;
    logic [31:0] pc_out;
    logic        valid;

    logic [15:0] mem [0:4095];
    int          checks = 0;
    int          passed = 0;

    fetch_controller #(.RESET_VEC(32'h0), .IMM_PREFIX(2'b11)) dut (
        .clk(clk), .rst_n(rst_n), .mem_address(mem_address), .mem_read(mem_read),
        .mem_write(mem_write), .mem_CS(mem_CS), .mem_writeData(mem_writeData),
        .mem_readData(mem_readData), .stall(stall), .branch_taken(branch_taken),
        .branch_target(branch_target), .instr(instr), .imm(imm), .pc_out(pc_out),
        .valid(valid)
    );

    always #5 clk = ~clk;

    // The bench memory decodes only the low 12 address bits.
    assign mem_readData = mem[mem_address[11:0]];

    task automatic clear_mem();
        for (int i = 0; i < 4096; i++) mem[i] = 16'h0;
    endtask

    // Leaves the DUT just out of reset at a negedge, in VEC_LO.
    task automatic boot();
        stall = 1'b0;
        branch_taken = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if ({mem_read, mem_CS, mem_write, mem_writeData} !== 19'h0)
            $display("[TB] FAIL reset_strobes: got %h expected %h", {mem_read, mem_CS, mem_write, mem_writeData}, 19'h0);
        else passed++;
        checks++;
        if ({valid, instr, imm, pc_out, mem_address} !== 97'h0)
            $display("[TB] FAIL reset_outputs: got %h expected 0", {valid, instr, imm, pc_out, mem_address});
        else passed++;
    endtask

    task automatic test_boot();
        clear_mem();
        mem[0] = 16'h0020; mem[1] = 16'h0000; mem[32] = 16'h1940;
        boot();
        checks++;
        if ({mem_read, mem_CS, mem_address} !== {2'b11, 32'h0})
            $display("[TB] FAIL boot_addr0: got %h expected %h", {mem_read, mem_CS, mem_address}, {2'b11, 32'h0});
        else passed++;
        @(negedge clk);
        checks++;
        if (mem_address !== 32'h1) $display("[TB] FAIL boot_addr1: got %h expected %h", mem_address, 32'h1);
        else passed++;
        @(negedge clk);
        checks++;
        if ({valid, mem_address} !== {1'b0, 32'h20})
            $display("[TB] FAIL boot_addr_pc: got %h expected %h", {valid, mem_address}, {1'b0, 32'h20});
        else passed++;
        @(negedge clk);
        checks++;
        if ({valid, instr, pc_out, mem_address} !== {1'b1, 16'h1940, 32'h20, 32'h21})
            $display("[TB] FAIL boot_first_instr: got %h expected %h", {valid, instr, pc_out, mem_address}, {1'b1, 16'h1940, 32'h20, 32'h21});
        else passed++;
    endtask

    task automatic test_two_word();
        clear_mem();
        mem[0] = 16'h0020; mem[32] = 16'hC123; mem[33] = 16'h00FF;
        boot();
        repeat (3) @(negedge clk);
        checks++;
        if ({valid, mem_address} !== {1'b0, 32'h21})
            $display("[TB] FAIL imm_gap: got %h expected %h", {valid, mem_address}, {1'b0, 32'h21});
        else passed++;
        @(negedge clk);
        checks++;
        if ({valid, instr, imm, pc_out, mem_address} !== {1'b1, 16'hC123, 16'h00FF, 32'h20, 32'h22})
            $display("[TB] FAIL imm_complete: got %h expected %h", {valid, instr, imm, pc_out, mem_address}, {1'b1, 16'hC123, 16'h00FF, 32'h20, 32'h22});
        else passed++;
    endtask

    task automatic test_stall();
        logic [80:0] snap;
        clear_mem();
        mem[0] = 16'h0020;
        for (int i = 32; i < 40; i++) mem[i] = 16'h1000 + 16'(i);
        boot();
        repeat (3) @(negedge clk);
        snap = {valid, instr, pc_out, mem_address};
        stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checks++;
            if ({valid, instr, pc_out, mem_address} !== snap)
                $display("[TB] FAIL stall_hold_%0d: got %h expected %h", k, {valid, instr, pc_out, mem_address}, snap);
            else passed++;
        end
        stall = 1'b0;
        for (int k = 33; k < 35; k++) begin
            @(negedge clk);
            checks++;
            if ({valid, instr, pc_out} !== {1'b1, 16'h1000 + 16'(k), 32'(k)})
                $display("[TB] FAIL stall_resume_%0d: got %h expected %h", k, {valid, instr, pc_out}, {1'b1, 16'h1000 + 16'(k), 32'(k)});
            else passed++;
        end
    endtask

    task automatic test_branch_in_imm();
        clear_mem();
        mem[0] = 16'h0020; mem[32] = 16'hC000; mem[33] = 16'hBEEF; mem[64] = 16'h1234;
        boot();
        repeat (3) @(negedge clk);
        stall = 1'b1; branch_taken = 1'b1; branch_target = 32'h40;
        @(negedge clk);
        stall = 1'b0; branch_taken = 1'b0;
        checks++;
        if ({valid, instr, mem_address} !== {1'b0, 16'hC000, 32'h40})
            $display("[TB] FAIL branch_redirect: got %h expected %h", {valid, instr, mem_address}, {1'b0, 16'hC000, 32'h40});
        else passed++;
        @(negedge clk);
        checks++;
        if ({valid, instr, pc_out, mem_address} !== {1'b1, 16'h1234, 32'h40, 32'h41})
            $display("[TB] FAIL branch_fetch: got %h expected %h", {valid, instr, pc_out, mem_address}, {1'b1, 16'h1234, 32'h40, 32'h41});
        else passed++;
    endtask

    task automatic test_wrap_and_async_reset();
        clear_mem();
        mem[0] = 16'h0020; mem[4095] = 16'h0123;
        boot();
        repeat (2) @(negedge clk);
        branch_taken = 1'b1; branch_target = 32'hFFFF_FFFF;
        @(negedge clk);
        branch_taken = 1'b0;
        @(negedge clk);
        checks++;
        if ({valid, instr, pc_out, mem_address} !== {1'b1, 16'h0123, 32'hFFFF_FFFF, 32'h0})
            $display("[TB] FAIL wrap: got %h expected %h", {valid, instr, pc_out, mem_address}, {1'b1, 16'h0123, 32'hFFFF_FFFF, 32'h0});
        else passed++;
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({valid, instr, imm, pc_out, mem_read, mem_CS, mem_address} !== 99'h0)
            $display("[TB] FAIL async_reset: got %h expected 0", {valid, instr, imm, pc_out, mem_read, mem_CS, mem_address});
        else passed++;
    endtask

    // Instruction-level model: walk memory from exp_addr, one or two words per instruction,
    // consuming the presented instruction on each edge where valid=1 and stall=0.
    task automatic test_random();
        logic [31:0]  exp_addr, tgt;
        logic [15:0]  w0, w1;
        logic [112:0] snap;
        bit           have_snap, s, b;
        int           consumed;
        clear_mem();
        mem[0] = 16'd100;
        for (int i = 100; i < 4096; i++) mem[i] = 16'($urandom);
        boot();
        repeat (2) @(negedge clk);
        exp_addr = 32'd100;
        have_snap = 1'b0;
        consumed = 0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            @(negedge clk);
            if (have_snap) begin
                checks++;
                if ({valid, instr, imm, pc_out, mem_address} !== snap)
                    $display("[TB] FAIL rand_stall_hold cyc %0d: got %h expected %h", cyc, {valid, instr, imm, pc_out, mem_address}, snap);
                else passed++;
            end
            have_snap = 1'b0;
            s = ($urandom_range(0, 3) == 0);
            b = !s && ($urandom_range(0, 15) == 0);
            if (valid && !s) begin
                w0 = mem[exp_addr[11:0]];
                w1 = mem[12'(exp_addr + 32'd1)];
                checks++;
                if ({instr, pc_out} !== {w0, exp_addr})
                    $display("[TB] FAIL rand_instr cyc %0d: got %h expected %h", cyc, {instr, pc_out}, {w0, exp_addr});
                else passed++;
                if (w0[15:14] == 2'b11) begin
                    checks++;
                    if (imm !== w1) $display("[TB] FAIL rand_imm cyc %0d: got %h expected %h", cyc, imm, w1);
                    else passed++;
                    exp_addr = exp_addr + 32'd2;
                end else begin
                    exp_addr = exp_addr + 32'd1;
                end
                consumed++;
            end
            if (b) begin
                tgt = 32'd100 + 32'($urandom_range(0, 400));
                branch_target = tgt;
                exp_addr = tgt;
            end
            stall = s;
            branch_taken = b;
            if (s) begin
                snap = {valid, instr, imm, pc_out, mem_address};
                have_snap = 1'b1;
            end
        end
        @(negedge clk);
        stall = 1'b0; branch_taken = 1'b0;
        checks++;
        if (consumed < 50) $display("[TB] FAIL rand_progress: got %0d instructions expected at least 50", consumed);
        else passed++;
    endtask

    initial begin
        test_reset();
        test_boot();
        test_two_word();
        test_stall();
        test_branch_in_imm();
        test_wrap_and_async_reset();
        test_random();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
